// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: the serial line in, plus the published word and its flags.
//
// Handshake: po_flag is a valid strobe with no ready. It is high for exactly one
// cycle per received frame, and po_data and the three error flags are valid in
// that cycle. They then hold their values until the next frame is published.
// The consumer must capture the word in the po_flag cycle because the receiver
// never stalls.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] po_data;
    logic                 po_flag;
    logic                 po_parity_err;
    logic                 po_frame_err;
    logic                 po_break;

    // Line driver / word consumer side
    modport master (
        output rx,
        input  po_data, po_flag, po_parity_err, po_frame_err, po_break
    );

    // Receiver side
    modport slave (
        input  rx,
        output po_data, po_flag, po_parity_err, po_frame_err, po_break
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver. It uses a two-flop synchroniser and 3-sample majority
// bit decisions, and rejects false starts. Each frame is published as one
// registered word with parity, framing and break flags.
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BPS  = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    uart_rx_cfg_if.slave  bus,
    output logic [2:0]    fsm_state
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int MID          = BAUD_CNT_MAX / 2 - 1;
    localparam int CNT_W        = $clog2(BAUD_CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(MID);
    localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(MID + 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic                 rx_s1, rx_s2, rx_d;
    logic [CNT_W-1:0]     cnt;
    logic                 samp_a, samp_b;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_err, frm_err, all_zero;

    logic start_edge, bit_val, bit_tick, par_exp, brk_now, frm_now;

    assign fsm_state  = state;
    assign start_edge = ~rx_s2 & rx_d;
    assign bit_val    = (samp_a & samp_b) | (samp_a & rx_s2) | (samp_b & rx_s2);
    assign bit_tick   = (state != S_IDLE) && (cnt == SMP_C);
    assign par_exp    = (PARITY == 1) ? ~^shift : ^shift;
    // Break only looks at the first stop bit; the second one counts toward framing only.
    assign brk_now    = all_zero & ~((bit_idx == 4'd0) & bit_val);
    assign frm_now    = frm_err | ~bit_val;

    // Synchronise rx and keep a delayed copy for falling-edge detection.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= bus.rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // Baud counter: parked at 0 while idle, free-running modulo BAUD_CNT_MAX in a frame.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)                cnt <= '0;
        else if (state == S_IDLE)   cnt <= '0;
        else if (cnt == CNT_LAST)   cnt <= '0;
        else                        cnt <= cnt + 1'b1;
    end

    // Capture the first two of the three mid-bit samples; the third is taken live.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (cnt == SMP_A) samp_a <= rx_s2;
            if (cnt == SMP_B) samp_b <= rx_s2;
        end
    end

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic: every transition out of a frame state happens on a bit decision.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_edge) state_nxt = S_START;
            S_START: if (bit_tick)   state_nxt = bit_val ? S_IDLE : S_DATA;
            S_DATA:  if (bit_tick && bit_idx == DATA_LAST)
                         state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (bit_tick)   state_nxt = S_STOP;
            S_STOP:  if (bit_tick && bit_idx == STOP_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frame datapath: shift data, accumulate errors, publish on the last stop decision.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bit_idx           <= '0;
            shift             <= '0;
            par_err           <= 1'b0;
            frm_err           <= 1'b0;
            all_zero          <= 1'b0;
            bus.po_data       <= '0;
            bus.po_flag       <= 1'b0;
            bus.po_parity_err <= 1'b0;
            bus.po_frame_err  <= 1'b0;
            bus.po_break      <= 1'b0;
        end else begin
            bus.po_flag <= 1'b0;
            if (bit_tick) begin
                case (state)
                    S_START: begin
                        bit_idx  <= '0;
                        par_err  <= 1'b0;
                        frm_err  <= 1'b0;
                        all_zero <= 1'b1;
                    end
                    S_DATA: begin
                        shift   <= {bit_val, shift[DATA_BITS-1:1]};
                        bit_idx <= (bit_idx == DATA_LAST) ? 4'd0 : bit_idx + 4'd1;
                        if (bit_val) all_zero <= 1'b0;
                    end
                    S_PAR: begin
                        if (bit_val != par_exp) par_err <= 1'b1;
                        if (bit_val) all_zero <= 1'b0;
                    end
                    S_STOP: begin
                        frm_err <= frm_now;
                        if (bit_idx == 4'd0 && bit_val) all_zero <= 1'b0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx           <= '0;
                            bus.po_data       <= brk_now ? '0 : shift;
                            bus.po_parity_err <= (PARITY != 0) && par_err;
                            bus.po_frame_err  <= frm_now | brk_now;
                            bus.po_break      <= brk_now;
                            bus.po_flag       <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four receivers (8N1, 8E1, 8O1, 7O2) on separate lines,
// a frame table, hand-written corner sequences and per-channel expected queues.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    localparam int CLK_FREQ = 1_000_000;
    localparam int UART_BPS = 100_000;
    localparam int BIT      = 10;

    // ---------------- clock / reset ----------------
    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [3:0] rx_line;
    logic [2:0] st0, st1, st2, st3;

    always #5 sys_clk = ~sys_clk;

    uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if2 ();
    uart_rx_cfg_if #(.DATA_BITS(7)) if3 ();

    assign if0.rx = rx_line[0];
    assign if1.rx = rx_line[1];
    assign if2.rx = rx_line[2];
    assign if3.rx = rx_line[3];

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(if0.slave), .fsm_state(st0));
    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        u1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(if1.slave), .fsm_state(st1));
    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        u2 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(if2.slave), .fsm_state(st2));
    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2))
        u3 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(if3.slave), .fsm_state(st3));

    // ---------------- scoreboard ----------------
    // Record layout: {break, frame_err, parity_err, data[8:0]}
    logic [11:0] exp_q0[$];
    logic [11:0] exp_q1[$];
    logic [11:0] exp_q2[$];
    logic [11:0] exp_q3[$];
    int checks = 0;
    int passes = 0;
    int flag_cnt [4];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input int ch, input logic [11:0] e);
        case (ch)
            0: exp_q0.push_back(e);
            1: exp_q1.push_back(e);
            2: exp_q2.push_back(e);
            default: exp_q3.push_back(e);
        endcase
    endtask

    task automatic got(input int ch, input logic [11:0] act);
        logic [11:0] e;
        int n;
        flag_cnt[ch]++;
        case (ch)
            0: n = exp_q0.size();
            1: n = exp_q1.size();
            2: n = exp_q2.size();
            default: n = exp_q3.size();
        endcase
        if (n == 0) begin
            checks++;
            $display("FAIL ch%0d frame: got %h expected no frame", ch, act);
        end else begin
            case (ch)
                0: e = exp_q0.pop_front();
                1: e = exp_q1.pop_front();
                2: e = exp_q2.pop_front();
                default: e = exp_q3.pop_front();
            endcase
            check($sformatf("ch%0d frame", ch), act, e);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge sys_clk) begin
        if (if0.po_flag) got(0, {if0.po_break, if0.po_frame_err, if0.po_parity_err, 1'b0, if0.po_data});
        if (if1.po_flag) got(1, {if1.po_break, if1.po_frame_err, if1.po_parity_err, 1'b0, if1.po_data});
        if (if2.po_flag) got(2, {if2.po_break, if2.po_frame_err, if2.po_parity_err, 1'b0, if2.po_data});
        if (if3.po_flag) got(3, {if3.po_break, if3.po_frame_err, if3.po_parity_err, 2'b00, if3.po_data});
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic set_rx(input int ch, input logic b);
        rx_line[ch] = b;
    endtask

    // One bit time; an optional 1-cycle low glitch lands on the middle majority sample.
    task automatic drive_bit(input int ch, input logic b, input logic glitch);
        set_rx(ch, b);
        if (glitch) begin
            tick(5);
            set_rx(ch, 1'b0);
            tick(1);
            set_rx(ch, b);
            tick(4);
        end else begin
            tick(BIT);
        end
    endtask

    function automatic int nd_of(input int ch);
        return (ch == 3) ? 7 : 8;
    endfunction
    function automatic int par_of(input int ch);
        return (ch == 0) ? 0 : ((ch == 1) ? 2 : 1);
    endfunction
    function automatic int nstop_of(input int ch);
        return (ch == 3) ? 2 : 1;
    endfunction

    // par_force < 0 sends the correct parity; glitch_bit is the frame bit index (start = 0).
    task automatic send_frame(input int ch, input logic [8:0] data, input int par_force,
                              input logic stop_val, input int glitch_bit);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nd_of(ch); i++) p = p ^ data[i];
        if (par_of(ch) == 1) p = ~p;
        drive_bit(ch, 1'b0, glitch_bit == 0);
        for (int i = 0; i < nd_of(ch); i++) drive_bit(ch, data[i], glitch_bit == i + 1);
        if (par_of(ch) != 0) drive_bit(ch, (par_force < 0) ? p : par_force[0], 1'b0);
        drive_bit(ch, stop_val, 1'b0);
        for (int i = 1; i < nstop_of(ch); i++) drive_bit(ch, 1'b1, 1'b0);
    endtask

    // ---------------- test ----------------
    typedef struct {
        int         ch;
        logic [8:0] data;
        int         par_force;
        logic       stop_val;
        logic [2:0] exp_err;   // {break, frame_err, parity_err}
    } vec_t;

    vec_t vecs [13];
    int   f0;

    initial begin
        vecs[0]  = '{0, 9'h055, -1, 1'b1, 3'b000};
        vecs[1]  = '{0, 9'h03C, -1, 1'b0, 3'b010};
        vecs[2]  = '{0, 9'h081, -1, 1'b1, 3'b000};
        vecs[3]  = '{0, 9'h000, -1, 1'b1, 3'b000};
        vecs[4]  = '{0, 9'h0FF, -1, 1'b1, 3'b000};
        vecs[5]  = '{1, 9'h0A3,  1, 1'b1, 3'b001};
        vecs[6]  = '{1, 9'h0A3, -1, 1'b1, 3'b000};
        vecs[7]  = '{2, 9'h0A3,  1, 1'b1, 3'b000};
        vecs[8]  = '{2, 9'h0A3,  0, 1'b1, 3'b001};
        vecs[9]  = '{3, 9'h05A, -1, 1'b1, 3'b000};
        vecs[10] = '{3, 9'h000, -1, 1'b1, 3'b000};
        vecs[11] = '{3, 9'h07F,  1, 1'b1, 3'b001};
        vecs[12] = '{2, 9'h000,  0, 1'b0, 3'b111};
        for (int i = 0; i < 4; i++) flag_cnt[i] = 0;

        // Reset state
        rx_line = 4'hF;
        sys_rst = 1'b1;
        tick(3);
        check("rst ch0 out", {if0.po_break, if0.po_frame_err, if0.po_parity_err, if0.po_flag, if0.po_data}, 12'h000);
        check("rst ch3 out", {if3.po_break, if3.po_frame_err, if3.po_parity_err, if3.po_flag, 1'b0, if3.po_data}, 12'h000);
        check("rst states", {st0, st1, st2, st3}, 12'h000);
        sys_rst = 1'b0;
        tick(5);

        // Back-to-back 0x55 (with a glitch on data bit 2) then 0xA3
        push(0, {3'b000, 9'h055});
        push(0, {3'b000, 9'h0A3});
        send_frame(0, 9'h055, -1, 1'b1, 3);
        send_frame(0, 9'h0A3, -1, 1'b1, -1);
        tick(2 * BIT);

        // Frame table
        for (int i = 0; i < 13; i++) begin
            push(vecs[i].ch, {vecs[i].exp_err, vecs[i].data});
            send_frame(vecs[i].ch, vecs[i].data, vecs[i].par_force, vecs[i].stop_val, -1);
            set_rx(vecs[i].ch, 1'b1);
            tick(2 * BIT);
        end

        // False start: 3 low cycles are rejected, then a clean 0x7E
        set_rx(0, 1'b0);
        tick(3);
        set_rx(0, 1'b1);
        tick(2);
        check("false start in START", {9'h0, st0}, 12'h001);
        tick(5);
        check("false start back in IDLE", {9'h0, st0}, 12'h000);
        tick(BIT);
        push(0, {3'b000, 9'h07E});
        send_frame(0, 9'h07E, -1, 1'b1, -1);
        tick(2 * BIT);

        // Line stuck low for 15 bit times: exactly one break frame
        f0 = flag_cnt[0];
        push(0, {3'b110, 9'h000});
        set_rx(0, 1'b0);
        tick(15 * BIT);
        check("stuck low frames before release", 12'(flag_cnt[0] - f0), 12'd1);
        set_rx(0, 1'b1);
        tick(4 * BIT);
        check("stuck low frames after release", 12'(flag_cnt[0] - f0), 12'd1);

        // Reset during data bit 3 of a 7O2 frame, then a clean 0x5A
        set_rx(3, 1'b0);
        tick(BIT);
        for (int i = 0; i < 3; i++) begin
            set_rx(3, vecs[9].data[i]);
            tick(BIT);
        end
        set_rx(3, vecs[9].data[3]);
        tick(5);
        check("ch3 data before reset", {5'h0, if3.po_data}, 12'h07F);
        sys_rst = 1'b1;
        #1;
        check("mid-frame rst ch3 out", {if3.po_break, if3.po_frame_err, if3.po_parity_err, if3.po_flag, 1'b0, if3.po_data}, 12'h000);
        check("mid-frame rst ch3 state", {9'h0, st3}, 12'h000);
        set_rx(3, 1'b1);
        tick(2);
        sys_rst = 1'b0;
        tick(2 * BIT);
        push(3, {3'b000, 9'h05A});
        send_frame(3, 9'h05A, -1, 1'b1, -1);
        tick(3 * BIT);

        // Every expected frame must have been seen
        check("ch0 frames left", 12'(exp_q0.size()), 12'd0);
        check("ch1 frames left", 12'(exp_q1.size()), 12'd0);
        check("ch2 frames left", 12'(exp_q2.size()), 12'd0);
        check("ch3 frames left", 12'(exp_q3.size()), 12'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
